// File: rtl/sha2_256_core.sv
// SHA-224/SHA-256 compression core, UNROLL rounds per clock, chains pre-padded 512-bit blocks.
// Latency: done pulses 64/UNROLL+1 cycles after the accepting edge; ready rises together with done.
// Backpressure: start is honoured only while ready=1; starts seen while busy are dropped.
module sha2_256_core #(
  parameter int UNROLL = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic         first_block,
  input  logic         mode_224,
  input  logic [511:0] block_in,
  output logic         ready,
  output logic         done,
  output logic [255:0] digest
);

  generate
    if (UNROLL != 1 && UNROLL != 2 && UNROLL != 4 && UNROLL != 8) begin : g_bad_unroll
      $error("sha2_256_core: UNROLL must be 1, 2, 4 or 8");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, ROUNDS, FINAL} state_t;

  localparam logic [31:0] K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  localparam logic [31:0] IV256 [8] = '{
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  localparam logic [31:0] IV224 [8] = '{
    32'hc1059ed8, 32'h367cd507, 32'h3070dd17, 32'hf70e5939,
    32'hffc00b31, 32'h68581511, 32'h64f98fa7, 32'hbefa4fa4
  };

  function automatic logic [31:0] bsig0(input logic [31:0] x);
    return {x[1:0], x[31:2]} ^ {x[12:0], x[31:13]} ^ {x[21:0], x[31:22]};
  endfunction

  function automatic logic [31:0] bsig1(input logic [31:0] x);
    return {x[5:0], x[31:6]} ^ {x[10:0], x[31:11]} ^ {x[24:0], x[31:25]};
  endfunction

  function automatic logic [31:0] ssig0(input logic [31:0] x);
    return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ {3'b000, x[31:3]};
  endfunction

  function automatic logic [31:0] ssig1(input logic [31:0] x);
    return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ {10'b0, x[31:10]};
  endfunction

  state_t        state_q, state_d;
  logic [6:0]    cnt_q;
  logic          mode_q;
  logic          done_q;
  logic [255:0]  digest_q, digest_d;
  logic [31:0]   h_q [8];
  logic [31:0]   v_q [8];       // working variables a..h
  logic [31:0]   w_q [16];      // schedule window, w_q[0] = W[t]
  logic [31:0]   v_d [8];
  logic [31:0]   w_d [16];
  logic [31:0]   h_sum [8];
  logic [31:0]   ext [16+UNROLL];
  logic [31:0]   t1, t2;

  assign ready  = (state_q == IDLE);
  assign done   = done_q;
  assign digest = digest_q;

  // UNROLL chained rounds on the working variables using the first UNROLL window words
  always_comb begin
    v_d = v_q;
    t1  = '0;
    t2  = '0;
    for (int j = 0; j < UNROLL; j++) begin
      t1 = v_d[7] + bsig1(v_d[4]) + ((v_d[4] & v_d[5]) ^ (~v_d[4] & v_d[6]))
         + K[cnt_q[5:0] + 6'(j)] + w_q[j];
      t2 = bsig0(v_d[0]) + ((v_d[0] & v_d[1]) ^ (v_d[0] & v_d[2]) ^ (v_d[1] & v_d[2]));
      v_d[7] = v_d[6];
      v_d[6] = v_d[5];
      v_d[5] = v_d[4];
      v_d[4] = v_d[3] + t1;
      v_d[3] = v_d[2];
      v_d[2] = v_d[1];
      v_d[1] = v_d[0];
      v_d[0] = t1 + t2;
    end
  end

  // Extend the schedule by UNROLL words and slide the window forward by the same amount
  always_comb begin
    for (int i = 0; i < 16; i++) ext[i] = w_q[i];
    for (int k = 0; k < UNROLL; k++) begin
      ext[16+k] = ssig1(ext[14+k]) + ext[9+k] + ssig0(ext[1+k]) + ext[k];
    end
    for (int i = 0; i < 16; i++) w_d[i] = ext[i+UNROLL];
  end

  // Feed-forward sum and the digest image it produces (low word blanked for SHA-224)
  always_comb begin
    for (int i = 0; i < 8; i++) h_sum[i] = h_q[i] + v_q[i];
    digest_d = {h_sum[0], h_sum[1], h_sum[2], h_sum[3],
                h_sum[4], h_sum[5], h_sum[6], mode_q ? 32'h0 : h_sum[7]};
  end

  // Next-state logic: one FINAL cycle after the last group of rounds
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = ROUNDS;
      ROUNDS:  if (cnt_q == 7'(64 - UNROLL)) state_d = FINAL;
      FINAL:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Datapath registers: block capture, round progress, feed-forward and digest publication
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q    <= '0;
      mode_q   <= 1'b0;
      done_q   <= 1'b0;
      digest_q <= '0;
      for (int i = 0; i < 8; i++) begin
        h_q[i] <= IV256[i];
        v_q[i] <= '0;
      end
      for (int i = 0; i < 16; i++) w_q[i] <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            cnt_q <= '0;
            for (int i = 0; i < 16; i++) w_q[i] <= block_in[511-32*i -: 32];
            if (first_block) begin
              mode_q <= mode_224;
              for (int i = 0; i < 8; i++) begin
                h_q[i] <= mode_224 ? IV224[i] : IV256[i];
                v_q[i] <= mode_224 ? IV224[i] : IV256[i];
              end
            end else begin
              for (int i = 0; i < 8; i++) v_q[i] <= h_q[i];
            end
          end
        end
        ROUNDS: begin
          v_q   <= v_d;
          w_q   <= w_d;
          cnt_q <= cnt_q + 7'(UNROLL);
        end
        FINAL: begin
          h_q      <= h_sum;
          digest_q <= digest_d;
          done_q   <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sha2_256_core.sv
// Bench for sha2_256_core: four instances with UNROLL = 1, 2, 4, 8 sharing data inputs.
// Expected digests and latencies are queued when a block is issued and checked on done.
// Each instance has its own start; only one instance is exercised at a time.
module tb_sha2_256_core;

  localparam logic [511:0] BLK_ABC   = {32'h61626380, {14{32'h0}}, 32'h00000018};
  localparam logic [511:0] BLK_EMPTY = {32'h80000000, {15{32'h0}}};
  localparam logic [511:0] BLK_TWO1  = {32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
                                        32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
                                        32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
                                        32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
  localparam logic [511:0] BLK_TWO2  = {{15{32'h0}}, 32'h000001c0};

  localparam logic [255:0] DIG_ABC256 = 256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad;
  localparam logic [255:0] DIG_ABC224 = 256'h23097d22_3405d822_8642a477_bda255b3_2aadbce4_bda0b3f7_e36c9da7_00000000;
  localparam logic [255:0] DIG_TWO    = 256'h248d6a61_d20638b8_e5c02693_0c3e6039_a33ce459_64ff2167_f6ecedd4_19db06c1;
  localparam logic [255:0] DIG_EMPTY  = 256'he3b0c442_98fc1c14_9afbf4c8_996fb924_27ae41e4_649b934c_a495991b_7852b855;

  typedef struct {
    logic [255:0] dig;
    bit           chk;
    int           lat;
  } exp_t;

  logic         clk = 1'b0;
  logic         reset;
  logic         first_block;
  logic         mode_224;
  logic [511:0] block_in;
  logic         start_s  [4];
  logic         ready_s  [4];
  logic         done_s   [4];
  logic [255:0] digest_s [4];

  exp_t sb_q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_dut
      sha2_256_core #(.UNROLL(1 << gi)) u_dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start_s[gi]),
        .first_block (first_block),
        .mode_224    (mode_224),
        .block_in    (block_in),
        .ready       (ready_s[gi]),
        .done        (done_s[gi]),
        .digest      (digest_s[gi])
      );
    end
  endgenerate

  function automatic int lat_of(input int u);
    return 64 / (1 << u) + 1;
  endfunction

  task automatic push_exp(input logic [255:0] dig, input bit chk, input int lat);
    exp_t e;
    e.dig = dig;
    e.chk = chk;
    e.lat = lat;
    sb_q.push_back(e);
  endtask

  // Called at a negedge; presents a block, lets the next posedge accept it, returns at the following negedge.
  task automatic issue(input int u, input logic [511:0] blk, input logic fb, input logic m);
    n_cmp++;
    if (ready_s[u] !== 1'b1) begin
      n_err++;
      $display("FAIL issue_ready u=%0d: got %b, want 1", u, ready_s[u]);
    end
    start_s[u]  = 1'b1;
    block_in    = blk;
    first_block = fb;
    mode_224    = m;
    @(posedge clk);
    @(negedge clk);
    start_s[u]  = 1'b0;
    block_in    = {16{$urandom()}};
    first_block = 1'($urandom_range(0, 1));
    mode_224    = 1'($urandom_range(0, 1));
  endtask

  // Waits (bounded) for done, checks latency, ready-low while busy and the queued digest.
  task automatic wait_done(input int u, input int busy_at, input bit linger);
    exp_t e;
    int   cyc;
    bit   seen;
    bit   rdy_ok;
    cyc    = 0;
    seen   = 0;
    rdy_ok = (ready_s[u] === 1'b0);
    if (sb_q.size() == 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL scoreboard_empty u=%0d: got 0 entries, want 1", u);
      return;
    end
    e = sb_q.pop_front();
    while (!seen && cyc < e.lat + 20) begin
      if (cyc == busy_at) begin
        start_s[u]  = 1'b1;
        block_in    = {16{$urandom()}};
        first_block = 1'b1;
        mode_224    = 1'b1;
      end
      @(posedge clk);
      @(negedge clk);
      cyc++;
      start_s[u] = 1'b0;
      if (done_s[u] === 1'b1) seen = 1;
      else if (ready_s[u] !== 1'b0) rdy_ok = 0;
    end
    n_cmp++;
    if (!seen || cyc != e.lat) begin
      n_err++;
      $display("FAIL done_latency u=%0d: got %0d (seen=%0d), want %0d", u, cyc, seen, e.lat);
    end
    n_cmp++;
    if (!rdy_ok) begin
      n_err++;
      $display("FAIL ready_while_busy u=%0d: got ready high during rounds, want low", u);
    end
    if (e.chk) begin
      n_cmp++;
      if (digest_s[u] !== e.dig) begin
        n_err++;
        $display("FAIL digest u=%0d: got %h, want %h", u, digest_s[u], e.dig);
      end
    end
    if (linger) begin
      @(posedge clk);
      @(negedge clk);
      n_cmp++;
      if (done_s[u] !== 1'b0) begin
        n_err++;
        $display("FAIL done_single_pulse u=%0d: got %b, want 0", u, done_s[u]);
      end
      if (e.chk) begin
        n_cmp++;
        if (digest_s[u] !== e.dig) begin
          n_err++;
          $display("FAIL digest_hold u=%0d: got %h, want %h", u, digest_s[u], e.dig);
        end
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    #1 reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int u = 0; u < 4; u++) begin
      n_cmp++;
      if (ready_s[u] !== 1'b1) begin
        n_err++;
        $display("FAIL reset_ready u=%0d: got %b, want 1", u, ready_s[u]);
      end
      n_cmp++;
      if (done_s[u] !== 1'b0) begin
        n_err++;
        $display("FAIL reset_done u=%0d: got %b, want 0", u, done_s[u]);
      end
      n_cmp++;
      if (digest_s[u] !== 256'h0) begin
        n_err++;
        $display("FAIL reset_digest u=%0d: got %h, want 0", u, digest_s[u]);
      end
    end
    reset = 1'b0;
    @(negedge clk);
  endtask

  // SHA-256 "abc"; optionally fires an ignored start a few cycles into the rounds
  task automatic test_sha256_single(input int u, input bit busy);
    push_exp(DIG_ABC256, 1'b1, lat_of(u));
    issue(u, BLK_ABC, 1'b1, 1'b0);
    wait_done(u, busy ? 5 : -1, 1'b1);
  endtask

  task automatic test_sha224(input int u);
    push_exp(DIG_ABC224, 1'b1, lat_of(u));
    issue(u, BLK_ABC, 1'b1, 1'b1);
    wait_done(u, -1, 1'b1);
  endtask

  // Two-block message; block 2 starts in block 1's done cycle with mode_224=1 that must be ignored
  task automatic test_back_to_back(input int u);
    push_exp(256'h0, 1'b0, lat_of(u));
    push_exp(DIG_TWO, 1'b1, lat_of(u));
    issue(u, BLK_TWO1, 1'b1, 1'b0);
    wait_done(u, -1, 1'b0);
    issue(u, BLK_TWO2, 1'b0, 1'b1);
    wait_done(u, -1, 1'b1);
  endtask

  task automatic test_busy_reset(input int u);
    int pulses;
    issue(u, BLK_EMPTY, 1'b1, 1'b0);
    for (int cyc = 1; cyc <= 30; cyc++) begin
      @(posedge clk);
      @(negedge clk);
      if (cyc == 10) begin
        start_s[u] = 1'b1;
        block_in   = BLK_ABC;
      end
      if (cyc == 11) begin
        start_s[u] = 1'b0;
        n_cmp++;
        if (ready_s[u] !== 1'b0) begin
          n_err++;
          $display("FAIL busy_start_ignored u=%0d: got ready %b, want 0", u, ready_s[u]);
        end
      end
    end
    reset = 1'b1;
    #1;
    n_cmp++;
    if (ready_s[u] !== 1'b1) begin
      n_err++;
      $display("FAIL midreset_ready u=%0d: got %b, want 1", u, ready_s[u]);
    end
    n_cmp++;
    if (done_s[u] !== 1'b0) begin
      n_err++;
      $display("FAIL midreset_done u=%0d: got %b, want 0", u, done_s[u]);
    end
    n_cmp++;
    if (digest_s[u] !== 256'h0) begin
      n_err++;
      $display("FAIL midreset_digest u=%0d: got %h, want 0", u, digest_s[u]);
    end
    @(negedge clk);
    reset  = 1'b0;
    pulses = 0;
    for (int cyc = 0; cyc < 80; cyc++) begin
      @(posedge clk);
      @(negedge clk);
      if (done_s[u] === 1'b1) pulses++;
    end
    n_cmp++;
    if (pulses != 0) begin
      n_err++;
      $display("FAIL no_done_after_reset u=%0d: got %0d pulses, want 0", u, pulses);
    end
    // first_block=0 straight after reset chains from the SHA-256 IV; mode_224 is ignored
    push_exp(DIG_EMPTY, 1'b1, lat_of(u));
    issue(u, BLK_EMPTY, 1'b0, 1'b1);
    wait_done(u, -1, 1'b1);
  endtask

  initial begin
    for (int u = 0; u < 4; u++) start_s[u] = 1'b0;
    first_block = 1'b0;
    mode_224    = 1'b0;
    block_in    = '0;
    test_reset();
    test_sha256_single(0, 1'b1);
    test_sha224(2);
    test_back_to_back(0);
    test_busy_reset(0);
    test_sha256_single(1, 1'b0);
    test_back_to_back(1);
    test_sha256_single(3, 1'b1);
    test_back_to_back(3);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
